fpnew_opgroup_arbiter: RTL and testbench

FPNEW_OPGROUP_ARBITER -- requirements
Module: fpnew_opgroup_arbiter

---
 rtl/fpnew_opgroup_arbiter.sv | 151 +++++++++++++++
 tb/tb_fpnew_opgroup_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_opgroup_arbiter.sv
// Opgroup issue demux and round-robin result arbiter for the FP unit.
// Tracks in-flight operations and returns one result per cycle downstream.
package fpnew_arb_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL,
    DIV, SQRT,
    SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [1:0] {
    ADDMUL, DIVSQRT, NONCOMP, CONV
  } opgroup_e;

  function automatic opgroup_e get_opgroup(
    input operation_e op
  );
    case (op)
      FMADD, FNMSUB, ADD, MUL: return ADDMUL;
      DIV, SQRT: return DIVSQRT;
      SGNJ, MINMAX, CMP, CLASSIFY: return NONCOMP;
      F2F, F2I, I2F, CPKAB, CPKCD: return CONV;
      default: return NONCOMP;
    endcase
  endfunction

endpackage

module fpnew_opgroup_arbiter
  import fpnew_arb_pkg::*;
#(
  parameter int unsigned Width          = 64,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [3:0]               op_i,
  input  logic [TagWidth-1:0]      tag_i,
  output logic [3:0]               grp_in_valid_o,
  input  logic [3:0]               grp_in_ready_i,
  input  logic [3:0]               grp_out_valid_i,
  output logic [3:0]               grp_out_ready_o,
  input  logic [3:0][Width-1:0]    grp_result_i,
  input  logic [3:0][4:0]          grp_status_i,
  input  logic [3:0][TagWidth-1:0] grp_tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [Width-1:0]         result_o,
  output logic [4:0]               status_o,
  output logic [TagWidth-1:0]      tag_o,
  output logic                     busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] count;
  logic [1:0]      rr_ptr;
  logic [1:0]      grp;
  logic            full;
  logic            slot_free;
  logic            found;
  logic            grant;
  logic [1:0]      winner;
  logic            accept;
  logic            deliver;

  // tag_i rides along to the opgroup; the arbiter itself never inspects it
  logic            unused_tag;
  assign unused_tag = ^tag_i;

  assign grp  = 2'(get_opgroup(operation_e'(op_i)));
  assign full = (count == CntMax);

  always_comb begin
    grp_in_valid_o = 4'b0000;
    if (rst_ni && in_valid_i && !flush_i && !full)
      grp_in_valid_o[grp] = 1'b1;
  end

  assign in_ready_o = rst_ni & grp_in_ready_i[grp]
                    & ~full & ~flush_i;

  assign slot_free = ~out_valid_o | out_ready_i;

  always_comb begin
    logic [1:0] idx;
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && grp_out_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant = found & slot_free & ~flush_i;

  // flush drains every opgroup so stale results cannot leak out later
  always_comb begin
    grp_out_ready_o = 4'b0000;
    if (!rst_ni)
      grp_out_ready_o = 4'b0000;
    else if (flush_i)
      grp_out_ready_o = 4'b1111;
    else if (grant)
      grp_out_ready_o[winner] = 1'b1;
  end

  assign accept  = in_valid_i & in_ready_o;
  assign deliver = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count       <= '0;
      rr_ptr      <= 2'd0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      status_o    <= '0;
      tag_o       <= '0;
    end else if (flush_i) begin
      count       <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (accept && !(deliver && count != '0))
        count <= count + CntW'(1);
      else if (!accept && deliver && count != '0)
        count <= count - CntW'(1);
      if (grant) begin
        out_valid_o <= 1'b1;
        result_o    <= grp_result_i[winner];
        status_o    <= grp_status_i[winner];
        tag_o       <= grp_tag_i[winner];
        rr_ptr      <= winner + 2'd1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (count != '0) | out_valid_o;

endmodule

// File: tb/tb_fpnew_opgroup_arbiter.sv
// Directed plus randomized checks of the opgroup arbiter
// against a cycle-level reference model.
module tb_fpnew_opgroup_arbiter;

  localparam int W    = 16;
  localparam int TW   = 4;
  localparam int MAXO = 4;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [3:0]          op_i;
  logic [TW-1:0]       tag_i;
  logic [3:0]          grp_in_valid_o;
  logic [3:0]          grp_in_ready_i;
  logic [3:0]          grp_out_valid_i;
  logic [3:0]          grp_out_ready_o;
  logic [3:0][W-1:0]   grp_result_i;
  logic [3:0][4:0]     grp_status_i;
  logic [3:0][TW-1:0]  grp_tag_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [W-1:0]        result_o;
  logic [4:0]          status_o;
  logic [TW-1:0]       tag_o;
  logic                busy_o;

  int vectors = 0;
  int miscompares = 0;

  int          m_cnt;
  int          m_rr;
  bit          m_ov;
  logic [W-1:0]  m_res;
  logic [4:0]    m_st;
  logic [TW-1:0] m_tag;

  fpnew_opgroup_arbiter #(
    .Width(W),
    .TagWidth(TW),
    .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .op_i(op_i),
    .tag_i(tag_i),
    .grp_in_valid_o(grp_in_valid_o),
    .grp_in_ready_i(grp_in_ready_i),
    .grp_out_valid_i(grp_out_valid_i),
    .grp_out_ready_o(grp_out_ready_o),
    .grp_result_i(grp_result_i),
    .grp_status_i(grp_status_i),
    .grp_tag_i(grp_tag_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o(result_o),
    .status_o(status_o),
    .tag_o(tag_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic int opgrp(input int op);
    if (op <= 3) return 0;
    if (op <= 5) return 1;
    if (op <= 9) return 2;
    if (op <= 14) return 3;
    return 2;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h",
             name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_i = 0; in_valid_i = 0; op_i = 0; tag_i = 0;
    grp_in_ready_i = 0; grp_out_valid_i = 0;
    out_ready_i = 0;
    grp_result_i = '0; grp_status_i = '0; grp_tag_i = '0;
  endtask

  // asynchronous reset asserted right now, between edges
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    chk("rst_grp_in_valid", 64'(grp_in_valid_o), 64'(0));
    chk("rst_grp_out_ready", 64'(grp_out_ready_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    clear_inputs();
    m_cnt = 0; m_rr = 0; m_ov = 0;
    m_res = '0; m_st = '0; m_tag = '0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // check one cycle against the model, then advance to next negedge
  task automatic cycle();
    int g, w, nc;
    bit full, rdy, sf, gnt, acc, del;
    logic [3:0] e_giv, e_gor;
    #1;
    g = opgrp(int'(op_i));
    full = (m_cnt == MAXO);
    rdy = grp_in_ready_i[g] && !full && !flush_i;
    e_giv = (in_valid_i && !flush_i && !full) ? 4'(1 << g) : 4'h0;
    sf = !m_ov || out_ready_i;
    gnt = 0; w = 0;
    if (!flush_i && sf)
      for (int k = 0; k < 4; k++)
        if (!gnt && grp_out_valid_i[(m_rr + k) % 4]) begin
          gnt = 1;
          w = (m_rr + k) % 4;
        end
    e_gor = flush_i ? 4'hf : (gnt ? 4'(1 << w) : 4'h0);
    chk("in_ready", 64'(in_ready_o), 64'(rdy));
    chk("grp_in_valid", 64'(grp_in_valid_o), 64'(e_giv));
    chk("grp_out_ready", 64'(grp_out_ready_o), 64'(e_gor));
    chk("out_valid", 64'(out_valid_o), 64'(m_ov));
    chk("result", 64'(result_o), 64'(m_res));
    chk("status", 64'(status_o), 64'(m_st));
    chk("tag", 64'(tag_o), 64'(m_tag));
    chk("busy", 64'(busy_o), 64'(m_cnt != 0 || m_ov));
    chk("count", 64'(dut.count), 64'(m_cnt));
    chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
    acc = in_valid_i && rdy;
    del = m_ov && out_ready_i;
    if (flush_i) begin
      m_cnt = 0;
      m_ov = 0;
    end else begin
      nc = m_cnt + (acc ? 1 : 0) - ((del && m_cnt > 0) ? 1 : 0);
      m_cnt = nc;
      if (gnt) begin
        m_ov = 1;
        m_res = grp_result_i[w];
        m_st = grp_status_i[w];
        m_tag = grp_tag_i[w];
        m_rr = (w + 1) % 4;
      end else if (out_ready_i) begin
        m_ov = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    do_reset();
    cycle();
    chk("reset_busy", 64'(busy_o), 64'(0));

    // issue a DIV into the divsqrt group
    op_i = 4'd4; tag_i = 4'd3;
    grp_in_ready_i = 4'b0010; in_valid_i = 1;
    #1;
    chk("div_grp_in_valid", 64'(grp_in_valid_o), 64'(4'b0010));
    chk("div_in_ready", 64'(in_ready_o), 64'(1));
    cycle();
    in_valid_i = 0;
    #1;
    chk("div_count", 64'(dut.count), 64'(1));
    chk("div_busy", 64'(busy_o), 64'(1));
    cycle();

    // all groups valid: strict rotation 0,1,2,3,0
    do_reset();
    for (int g = 0; g < 4; g++) begin
      grp_result_i[g] = 16'h100 + 16'(g);
      grp_status_i[g] = 5'(g + 1);
      grp_tag_i[g] = 4'(g + 8);
    end
    grp_out_valid_i = 4'b1111; out_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gor", 64'(grp_out_ready_o), 64'(1 << (i % 4)));
      cycle();
      chk("rr_result", 64'(result_o), 64'(16'h100 + 16'(i % 4)));
    end

    // backpressure holds the slot, then group 2 loads with no bubble
    out_ready_i = 0; grp_out_valid_i = 4'b0100;
    #1;
    chk("hold_gor", 64'(grp_out_ready_o), 64'(0));
    cycle();
    cycle();
    chk("hold_result", 64'(result_o), 64'(16'h100));
    out_ready_i = 1;
    #1;
    chk("release_gor", 64'(grp_out_ready_o), 64'(4'b0100));
    cycle();
    chk("release_result", 64'(result_o), 64'(16'h102));
    chk("release_valid", 64'(out_valid_o), 64'(1));

    // fill to the outstanding limit
    do_reset();
    for (int g = 0; g < 4; g++) grp_result_i[g] = 16'h200 + 16'(g);
    grp_in_ready_i = 4'b1111; in_valid_i = 1; op_i = 4'd2;
    repeat (MAXO) cycle();
    #1;
    chk("full_in_ready", 64'(in_ready_o), 64'(0));
    chk("full_grp_in_valid", 64'(grp_in_valid_o), 64'(0));
    in_valid_i = 0; grp_out_valid_i = 4'b0001;
    cycle();
    grp_out_valid_i = 4'b0000; out_ready_i = 1;
    cycle();
    out_ready_i = 0; in_valid_i = 1;
    #1;
    chk("after_deliver_in_ready", 64'(in_ready_o), 64'(1));
    in_valid_i = 0; grp_out_valid_i = 4'b0001;
    cycle();
    grp_out_valid_i = 4'b0000; in_valid_i = 1; out_ready_i = 1;
    cycle();
    chk("acc_del_count", 64'(dut.count), 64'(3));

    // flush with count=3 and a held result
    in_valid_i = 0; out_ready_i = 0; grp_out_valid_i = 4'b0010;
    cycle();
    grp_out_valid_i = 4'b0000; flush_i = 1;
    #1;
    chk("flush_gor", 64'(grp_out_ready_o), 64'(4'b1111));
    chk("flush_in_ready", 64'(in_ready_o), 64'(0));
    cycle();
    flush_i = 0;
    #1;
    chk("flush_out_valid", 64'(out_valid_o), 64'(0));
    chk("flush_count", 64'(dut.count), 64'(0));
    chk("flush_busy", 64'(busy_o), 64'(0));
    chk("flush_rr", 64'(dut.rr_ptr), 64'(2));
    cycle();

    // asynchronous reset mid-cycle with a valid result
    grp_out_valid_i = 4'b0001; out_ready_i = 0;
    cycle();
    in_valid_i = 1; grp_in_ready_i = 4'b1111; out_ready_i = 1;
    #2;
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        in_valid_i = 1'($urandom);
        op_i = 4'($urandom);
        tag_i = 4'($urandom);
        grp_in_ready_i = 4'($urandom);
        grp_out_valid_i = 4'($urandom);
        out_ready_i = ($urandom_range(3) != 0);
        flush_i = ($urandom_range(19) == 0);
        for (int g = 0; g < 4; g++) begin
          grp_result_i[g] = 16'($urandom);
          grp_status_i[g] = 5'($urandom);
          grp_tag_i[g] = 4'($urandom);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
